slow_clock_meter: RTL and testbench

SLOW_CLOCK_METER -- requirements
Module: slow_clock_meter

---
 rtl/slow_clock_meter_if.sv | 23 ++
 rtl/slow_clock_meter.sv | 82 ++++++++
 tb/tb_slow_clock_meter.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/slow_clock_meter_if.sv
// Measurement bus for slow_clock_meter: slow clock and clear in, period/high-time results out.
interface slow_clock_meter_if #(
    parameter int WIDTH = 28
);
    logic             Slow_In;
    logic             Clear;
    logic [WIDTH-1:0] Period;
    logic [WIDTH-1:0] High_Time;
    logic             Valid;
    logic             Locked;
    logic             Timeout;
    logic [15:0]      Edge_Count;

    modport master (
        output Slow_In, Clear,
        input  Period, High_Time, Valid, Locked, Timeout, Edge_Count
    );

    modport slave (
        input  Slow_In, Clear,
        output Period, High_Time, Valid, Locked, Timeout, Edge_Count
    );
endinterface

// File: rtl/slow_clock_meter.sv
// Measures period and high time of an asynchronous slow clock in Clk cycles,
// with lock tracking and a sticky loss-of-edge timeout.
module slow_clock_meter #(
    parameter int WIDTH   = 28,
    parameter int TIMEOUT = 134217728
) (
    input  logic               Clk,
    input  logic               Reset,
    slow_clock_meter_if.slave  bus
);
    typedef enum logic [1:0] {SEARCH = 2'd0, ARMED = 2'd1, LOCKED = 2'd2} state_t;

    localparam logic [WIDTH-1:0] TO_LAST = WIDTH'(TIMEOUT - 1);
    localparam logic [WIDTH-1:0] SAT_MAX = '1;
    localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

    state_t           state;
    logic             s1, s2, s3;
    logic [WIDTH-1:0] cnt, hcnt, period, high_time;
    logic             valid, timeout;
    logic [15:0]      edge_count;

    wire rise = s2 & ~s3;
    wire fall = ~s2 & s3;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            {s3, s2, s1} <= '0;
            state        <= SEARCH;
            cnt          <= '0;
            hcnt         <= '0;
            period       <= '0;
            high_time    <= '0;
            valid        <= 1'b0;
            timeout      <= 1'b0;
            edge_count   <= '0;
        end else begin
            // Synchronizer runs through Clear so a level already in flight is not lost.
            {s3, s2, s1} <= {s2, s1, bus.Slow_In};
            valid        <= 1'b0;
            if (bus.Clear) begin
                state      <= SEARCH;
                cnt        <= '0;
                hcnt       <= '0;
                period     <= '0;
                high_time  <= '0;
                timeout    <= 1'b0;
                edge_count <= '0;
            end else if (rise) begin
                cnt        <= '0;
                hcnt       <= ONE;
                edge_count <= edge_count + 16'd1;
                if (state != SEARCH) begin
                    period <= cnt + ONE;
                    valid  <= 1'b1;
                    state  <= LOCKED;
                end else begin
                    state  <= ARMED;
                end
            end else begin
                if (fall && state != SEARCH)
                    high_time <= hcnt;
                if (s2 && hcnt != SAT_MAX)
                    hcnt <= hcnt + ONE;
                if (cnt == TO_LAST) begin
                    cnt     <= '0;
                    timeout <= 1'b1;
                    state   <= SEARCH;
                end else if (cnt != SAT_MAX) begin
                    cnt <= cnt + ONE;
                end
            end
        end
    end

    assign bus.Period     = period;
    assign bus.High_Time  = high_time;
    assign bus.Valid      = valid;
    assign bus.Locked     = (state == LOCKED);
    assign bus.Timeout    = timeout;
    assign bus.Edge_Count = edge_count;
endmodule

// File: tb/tb_slow_clock_meter.sv
// Randomized and directed bench for slow_clock_meter against a cycle-level reference model.
module tb_slow_clock_meter;
    localparam int WIDTH   = 8;
    localparam int TIMEOUT = 50;

    logic Clk = 1'b0;
    logic Reset = 1'b1;
    int   chk_cnt = 0;
    int   err_cnt = 0;

    slow_clock_meter_if #(.WIDTH(WIDTH)) bus ();

    slow_clock_meter #(.WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    always #5 Clk = ~Clk;

    // Reference: Slow_In samples delayed by a 3-deep history; meter rules in plain integers.
    int  m_hist[3];
    int  m_mode;          // 0 = no edge yet, 1 = one rise seen, 2 = locked
    int  m_since_rise, m_high_run, m_period, m_high, m_edges;
    bit  m_valid, m_to;

    task automatic model_reset();
        m_hist = '{0, 0, 0};
        m_mode = 0; m_since_rise = 0; m_high_run = 0;
        m_period = 0; m_high = 0; m_edges = 0;
        m_valid = 0; m_to = 0;
    endtask

    task automatic model_step(input bit slow, input bit clr);
        bit r, f;
        r = (m_hist[1] == 1) && (m_hist[2] == 0);
        f = (m_hist[1] == 0) && (m_hist[2] == 1);
        m_valid = 0;
        if (clr) begin
            m_mode = 0; m_since_rise = 0; m_high_run = 0;
            m_period = 0; m_high = 0; m_edges = 0; m_to = 0;
        end else if (r) begin
            m_edges = (m_edges + 1) % 65536;
            if (m_mode != 0) begin
                m_period = m_since_rise + 1;
                m_valid  = 1;
            end
            m_mode = (m_mode == 0) ? 1 : 2;
            m_since_rise = 0;
            m_high_run = 1;
        end else begin
            if (f && m_mode != 0) m_high = m_high_run;
            if (m_hist[1] == 1 && m_high_run < 255) m_high_run++;
            if (m_since_rise == TIMEOUT - 1) begin
                m_to = 1; m_mode = 0; m_since_rise = 0;
            end else if (m_since_rise < 255) begin
                m_since_rise++;
            end
        end
        m_hist[2] = m_hist[1];
        m_hist[1] = m_hist[0];
        m_hist[0] = slow;
    endtask

    task automatic chk(input string tag, input longint got, input longint exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic chk_all(input string tag);
        chk({tag, ".Valid"},      bus.Valid,      m_valid);
        chk({tag, ".Locked"},     bus.Locked,     m_mode == 2);
        chk({tag, ".Timeout"},    bus.Timeout,    m_to);
        chk({tag, ".Period"},     bus.Period,     m_period);
        chk({tag, ".High_Time"},  bus.High_Time,  m_high);
        chk({tag, ".Edge_Count"}, bus.Edge_Count, m_edges);
    endtask

    task automatic cyc(input bit slow, input bit clr);
        @(negedge Clk);
        bus.Slow_In = slow;
        bus.Clear   = clr;
        model_step(slow, clr);
        @(posedge Clk);
        #1 chk_all("cyc");
    endtask

    task automatic wave(input int hi, input int lo, input int clr_pct);
        for (int i = 0; i < hi + lo; i++)
            cyc(i < hi, $urandom_range(99) < clr_pct);
    endtask

    int vcount;

    initial begin
        bus.Slow_In = 1'b0;
        bus.Clear   = 1'b0;
        model_reset();
        #1 chk("reset.Period", bus.Period, 0);
        chk("reset.Locked", bus.Locked, 0);
        chk("reset.Edge_Count", bus.Edge_Count, 0);
        repeat (3) @(posedge Clk);
        @(negedge Clk) Reset = 1'b0;

        // Lock at period 10, high 4; the arming rise never strobes Valid
        vcount = 0;
        for (int w = 0; w < 2; w++)
            for (int i = 0; i < 10; i++) begin
                cyc(i < 4, 1'b0);
                if (bus.Valid) vcount++;
            end
        chk("lock.Period", bus.Period, 10);
        chk("lock.High_Time", bus.High_Time, 4);
        chk("lock.Locked", bus.Locked, 1);
        chk("lock.Edge_Count", bus.Edge_Count, 2);
        chk("lock.valid_pulses", vcount, 1);

        // Loss of edges: timeout, hold results, sticky across relock
        repeat (60) cyc(1'b0, 1'b0);
        chk("to.Timeout", bus.Timeout, 1);
        chk("to.Locked", bus.Locked, 0);
        chk("to.Period", bus.Period, 10);
        repeat (3) wave(4, 6, 0);
        chk("relock.Locked", bus.Locked, 1);
        chk("relock.Timeout", bus.Timeout, 1);

        // Period step 10 -> 20 with high 12
        repeat (2) wave(12, 8, 0);
        chk("step.Period", bus.Period, 20);
        chk("step.High_Time", bus.High_Time, 12);

        // Clear coincident with a detected rise while locked
        cyc(1'b1, 1'b0);
        cyc(1'b1, 1'b0);
        cyc(1'b1, 1'b1);
        chk("clr.Period", bus.Period, 0);
        chk("clr.Edge_Count", bus.Edge_Count, 0);
        chk("clr.Locked", bus.Locked, 0);
        chk("clr.Valid", bus.Valid, 0);
        chk("clr.Timeout", bus.Timeout, 0);
        wave(1, 9, 0);
        repeat (2) wave(4, 6, 0);
        chk("clr.relock", bus.Locked, 1);

        // Rise exactly at the timeout threshold wins
        repeat (3) wave(4, TIMEOUT - 4, 0);
        chk("edge49.Period", bus.Period, TIMEOUT);
        chk("edge49.Timeout", bus.Timeout, 0);
        chk("edge49.Locked", bus.Locked, 1);

        // Asynchronous reset between clock edges
        wave(4, 3, 0);
        #2 Reset = 1'b1;
        #1 chk("areset.Period", bus.Period, 0);
        chk("areset.High_Time", bus.High_Time, 0);
        chk("areset.Locked", bus.Locked, 0);
        chk("areset.Edge_Count", bus.Edge_Count, 0);
        chk("areset.Timeout", bus.Timeout, 0);
        model_reset();
        @(negedge Clk) Reset = 1'b0;
        bus.Slow_In = 1'b0;
        wave(4, 6, 0);
        chk("areset.first_rise_edges", bus.Edge_Count, 1);
        chk("areset.first_rise_locked", bus.Locked, 0);

        // Randomized phases, occasional long gaps and stray Clear pulses
        for (int w = 0; w < 60; w++) begin
            int hi, lo;
            hi = $urandom_range(2, 15);
            lo = ($urandom_range(9) == 0) ? $urandom_range(45, 70) : $urandom_range(2, 30);
            wave(hi, lo, 2);
        end

        $display("Simulation finished: %0d checks, %0d errors", chk_cnt, err_cnt);
        $finish;
    end
endmodule
